m_mc_ctrl: RTL and testbench

- Multi-cycle sequencer for the single-issue RV32I datapath (PC register, instruction memory, m_rf, immediate generator, adder/ALU, data memory).
- Steps each instruction through IF/ID/EX/MEM/WB and drives the write enables, memory strobes and next-PC select.
- Handshakes with instruction and data memories that have variable latency.
- Counts cycles and retired instructions; halts on SYSTEM, illegal opcode, or memory timeout.

---
 rtl/m_mc_ctrl.sv | 178 +++++++++++++++++
 tb/tb_m_mc_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/m_mc_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer for the RV32I datapath.
// Strobes are decoded from state, latched class and memory handshakes.
module m_mc_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             w_clk,
    input  logic             w_rst_n,
    input  logic [4:0]       w_opcode5,
    input  logic             w_br_taken,
    input  logic             w_imem_ready,
    input  logic             w_dmem_ready,
    output logic             w_imem_req,
    output logic             w_ir_we,
    output logic             w_rf_we,
    output logic             w_dmem_re,
    output logic             w_dmem_we,
    output logic             w_pc_we,
    output logic             w_pc_sel,
    output logic             w_retire,
    output logic [2:0]       w_state,
    output logic             w_halted,
    output logic             w_err,
    output logic [CNT_W-1:0] w_cycles,
    output logic [CNT_W-1:0] w_retired
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_R, C_IALU, C_LOAD, C_STORE, C_BRANCH,
        C_LUI, C_AUIPC, C_JAL, C_JALR, C_SYSTEM, C_ILLEGAL
    } cls_t;

    state_t      state;
    cls_t        cls;
    logic [15:0] wait_cnt;
    logic [15:0] wait_nxt;
    logic        wait_expired;
    cls_t        dec_cls;

    function automatic cls_t decode_cls(input logic [4:0] op);
        case (op)
            5'b01100: decode_cls = C_R;
            5'b00100: decode_cls = C_IALU;
            5'b00000: decode_cls = C_LOAD;
            5'b01000: decode_cls = C_STORE;
            5'b11000: decode_cls = C_BRANCH;
            5'b01101: decode_cls = C_LUI;
            5'b00101: decode_cls = C_AUIPC;
            5'b11011: decode_cls = C_JAL;
            5'b11001: decode_cls = C_JALR;
            5'b11100: decode_cls = C_SYSTEM;
            default:  decode_cls = C_ILLEGAL;
        endcase
    endfunction

    assign dec_cls      = decode_cls(w_opcode5);
    assign wait_nxt     = wait_cnt + 16'd1;
    assign wait_expired = (wait_nxt == 16'(MEM_TIMEOUT));
    assign w_state      = state;

    // Strobes are forced low while reset is held so nothing fires before the first fetch.
    always_comb begin
        w_imem_req = 1'b0;
        w_ir_we    = 1'b0;
        w_rf_we    = 1'b0;
        w_dmem_re  = 1'b0;
        w_dmem_we  = 1'b0;
        w_pc_we    = 1'b0;
        w_pc_sel   = 1'b0;
        w_retire   = 1'b0;
        if (w_rst_n) begin
            case (state)
                S_IF: begin
                    w_imem_req = 1'b1;
                    w_ir_we    = w_imem_ready;
                end
                S_EX: begin
                    if (cls == C_BRANCH) begin
                        w_pc_we  = 1'b1;
                        w_pc_sel = w_br_taken;
                        w_retire = 1'b1;
                    end
                end
                S_MEM: begin
                    w_dmem_re = (cls == C_LOAD);
                    w_dmem_we = (cls == C_STORE);
                    if (cls == C_STORE && w_dmem_ready) begin
                        w_pc_we  = 1'b1;
                        w_retire = 1'b1;
                    end
                end
                S_WB: begin
                    w_rf_we  = 1'b1;
                    w_pc_we  = 1'b1;
                    w_retire = 1'b1;
                    w_pc_sel = (cls == C_JAL) || (cls == C_JALR);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state     <= S_IF;
            cls       <= C_ILLEGAL;
            wait_cnt  <= 16'd0;
            w_halted  <= 1'b0;
            w_err     <= 1'b0;
            w_cycles  <= '0;
            w_retired <= '0;
        end else begin
            if (state != S_HALT)
                w_cycles <= w_cycles + CNT_W'(1);
            if (w_retire)
                w_retired <= w_retired + CNT_W'(1);
            case (state)
                S_IF: begin
                    if (w_imem_ready) begin
                        state    <= S_ID;
                        wait_cnt <= 16'd0;
                    end else if (wait_expired) begin
                        state    <= S_HALT;
                        w_err    <= 1'b1;
                        w_halted <= 1'b1;
                    end else begin
                        wait_cnt <= wait_nxt;
                    end
                end
                S_ID: begin
                    cls <= dec_cls;
                    if (dec_cls == C_SYSTEM || dec_cls == C_ILLEGAL) begin
                        state    <= S_HALT;
                        w_halted <= 1'b1;
                    end else begin
                        state <= S_EX;
                    end
                end
                S_EX: begin
                    if (cls == C_LOAD || cls == C_STORE)
                        state <= S_MEM;
                    else if (cls == C_BRANCH)
                        state <= S_IF;
                    else
                        state <= S_WB;
                end
                S_MEM: begin
                    if (w_dmem_ready) begin
                        state    <= (cls == C_LOAD) ? S_WB : S_IF;
                        wait_cnt <= 16'd0;
                    end else if (wait_expired) begin
                        state    <= S_HALT;
                        w_err    <= 1'b1;
                        w_halted <= 1'b1;
                    end else begin
                        wait_cnt <= wait_nxt;
                    end
                end
                S_WB: state <= S_IF;
                S_HALT: w_halted <= 1'b1;
                default: begin
                    state    <= S_HALT;
                    w_halted <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m_mc_ctrl.sv
// Directed bench for m_mc_ctrl; strobes checked per cycle as a packed vector
// {imem_req, ir_we, rf_we, dmem_re, dmem_we, pc_we, pc_sel, retire}.
module tb_m_mc_ctrl;

    logic        w_clk;
    logic        w_rst_n;
    logic [4:0]  w_opcode5;
    logic        w_br_taken;
    logic        w_imem_ready;
    logic        w_dmem_ready;
    logic        w_imem_req, w_ir_we, w_rf_we, w_dmem_re, w_dmem_we;
    logic        w_pc_we, w_pc_sel, w_retire;
    logic [2:0]  w_state;
    logic        w_halted, w_err;
    logic [31:0] w_cycles, w_retired;
    logic [7:0]  strb;

    int n_cmp = 0;
    int n_bad = 0;

    m_mc_ctrl #(.CNT_W(32), .MEM_TIMEOUT(4)) dut (
        .w_clk(w_clk), .w_rst_n(w_rst_n), .w_opcode5(w_opcode5),
        .w_br_taken(w_br_taken), .w_imem_ready(w_imem_ready),
        .w_dmem_ready(w_dmem_ready), .w_imem_req(w_imem_req),
        .w_ir_we(w_ir_we), .w_rf_we(w_rf_we), .w_dmem_re(w_dmem_re),
        .w_dmem_we(w_dmem_we), .w_pc_we(w_pc_we), .w_pc_sel(w_pc_sel),
        .w_retire(w_retire), .w_state(w_state), .w_halted(w_halted),
        .w_err(w_err), .w_cycles(w_cycles), .w_retired(w_retired)
    );

    assign strb = {w_imem_req, w_ir_we, w_rf_we, w_dmem_re,
                   w_dmem_we, w_pc_we, w_pc_sel, w_retire};

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs already applied after a falling edge; check then move to the next falling edge.
    task automatic step(input string tag, input logic [2:0] es, input logic [7:0] eb);
        #1;
        check({tag, " state"}, {29'd0, w_state}, {29'd0, es});
        check({tag, " strb"}, {24'd0, strb}, {24'd0, eb});
        @(negedge w_clk);
    endtask

    task automatic status(input string tag, input logic h, input logic e,
                          input logic [31:0] cyc, input logic [31:0] ret);
        #1;
        check({tag, " halted"}, {31'd0, w_halted}, {31'd0, h});
        check({tag, " err"}, {31'd0, w_err}, {31'd0, e});
        check({tag, " cycles"}, w_cycles, cyc);
        check({tag, " retired"}, w_retired, ret);
    endtask

    initial begin
        w_rst_n      = 1'b0;
        w_opcode5    = 5'b00000;
        w_br_taken   = 1'b0;
        w_imem_ready = 1'b1;
        w_dmem_ready = 1'b1;
        repeat (2) @(negedge w_clk);
        status("reset", 1'b0, 1'b0, 32'd0, 32'd0);
        check("reset strb", {24'd0, strb}, 32'd0);
        check("reset state", {29'd0, w_state}, 32'd0);
        w_rst_n = 1'b1;

        // addi x1,x0,3
        w_opcode5 = 5'b00100;
        step("addi IF", 3'd0, 8'hC0);
        step("addi ID", 3'd1, 8'h00);
        step("addi EX", 3'd2, 8'h00);
        step("addi WB", 3'd4, 8'h25);
        status("addi done", 1'b0, 1'b0, 32'd4, 32'd1);

        // lw, data ready arrives on the 4th MEM cycle (same edge as timeout)
        w_opcode5 = 5'b00000;
        step("lw IF", 3'd0, 8'hC0);
        step("lw ID", 3'd1, 8'h00);
        w_dmem_ready = 1'b0;
        step("lw EX", 3'd2, 8'h00);
        step("lw MEM1", 3'd3, 8'h10);
        step("lw MEM2", 3'd3, 8'h10);
        step("lw MEM3", 3'd3, 8'h10);
        w_dmem_ready = 1'b1;
        step("lw MEM4", 3'd3, 8'h10);
        step("lw WB", 3'd4, 8'h25);
        status("lw done", 1'b0, 1'b0, 32'd12, 32'd2);

        // beq taken, then not taken
        w_opcode5  = 5'b11000;
        w_br_taken = 1'b1;
        step("beqT IF", 3'd0, 8'hC0);
        step("beqT ID", 3'd1, 8'h00);
        step("beqT EX", 3'd2, 8'h07);
        status("beqT done", 1'b0, 1'b0, 32'd15, 32'd3);
        w_br_taken = 1'b0;
        step("beqN IF", 3'd0, 8'hC0);
        step("beqN ID", 3'd1, 8'h00);
        step("beqN EX", 3'd2, 8'h05);
        status("beqN done", 1'b0, 1'b0, 32'd18, 32'd4);

        // jal then sw
        w_opcode5 = 5'b11011;
        step("jal IF", 3'd0, 8'hC0);
        step("jal ID", 3'd1, 8'h00);
        step("jal EX", 3'd2, 8'h00);
        step("jal WB", 3'd4, 8'h27);
        w_opcode5 = 5'b01000;
        step("sw IF", 3'd0, 8'hC0);
        step("sw ID", 3'd1, 8'h00);
        step("sw EX", 3'd2, 8'h00);
        step("sw MEM", 3'd3, 8'h0D);
        status("sw done", 1'b0, 1'b0, 32'd26, 32'd6);

        // ecall halts from ID, counters freeze
        w_opcode5 = 5'b11100;
        step("ecall IF", 3'd0, 8'hC0);
        step("ecall ID", 3'd1, 8'h00);
        step("ecall H1", 3'd5, 8'h00);
        step("ecall H2", 3'd5, 8'h00);
        status("ecall halt", 1'b1, 1'b0, 32'd28, 32'd6);

        // asynchronous reset mid-cycle
        #2 w_rst_n = 1'b0;
        status("async rst", 1'b0, 1'b0, 32'd0, 32'd0);
        check("async rst strb", {24'd0, strb}, 32'd0);
        check("async rst state", {29'd0, w_state}, 32'd0);
        @(negedge w_clk);
        w_rst_n      = 1'b1;
        w_imem_ready = 1'b0;

        // fetch restarts, imem never ready -> timeout after 4 wait cycles
        step("to IF1", 3'd0, 8'h80);
        step("to IF2", 3'd0, 8'h80);
        step("to IF3", 3'd0, 8'h80);
        step("to IF4", 3'd0, 8'h80);
        step("to H1", 3'd5, 8'h00);
        w_imem_ready = 1'b1;
        step("to H2", 3'd5, 8'h00);
        status("timeout", 1'b1, 1'b1, 32'd4, 32'd0);

        // illegal opcode halts from ID without error
        w_rst_n = 1'b0;
        #2;
        @(negedge w_clk);
        w_rst_n   = 1'b1;
        w_opcode5 = 5'b11111;
        step("ill IF", 3'd0, 8'hC0);
        step("ill ID", 3'd1, 8'h00);
        step("ill H", 3'd5, 8'h00);
        status("illegal", 1'b1, 1'b0, 32'd2, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
